mc_ctrl: RTL and testbench

Multi-cycle control unit for the next-generation MIPS core; it replaces the single-cycle `ctrl` decoder with a state machine. Each instruction steps through FETCH/DECODE/EXE/MEM/WB. Memory accesses stall for a parameterised number of wait cycles. The unit also keeps a retired-instruction counter and a sticky illegal-opcode flag. It sits beside the multi-cycle datapath in the core top and drives every datapath write enable and mux select.

---
 rtl/mc_pkg.sv | 70 +++++++
 rtl/mc_decode.sv | 48 ++++
 rtl/mc_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle MIPS control unit.
// Holds the FSM state encoding, the opcode/funct constants of the
// supported instruction subset, the datapath select encodings and the
// one-hot instruction class produced by mc_decode.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXE    = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Next-PC source
  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JMP  = 2'd2;
  localparam logic [1:0] NPC_RS   = 2'd3;

  // GRF write data source
  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_MEM   = 2'd1;
  localparam logic [1:0] WD_PC    = 2'd2;

  // GRF destination register
  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  // ALU operation
  localparam logic [1:0] ALU_ADD  = 2'd0;
  localparam logic [1:0] ALU_SUB  = 2'd1;
  localparam logic [1:0] ALU_OR   = 2'd2;

  // One-hot instruction class; all-zero means illegal.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: purely combinational instruction classifier.
// Ports:
//   instr_i   [31:0]  instruction word
//   cls_o             one-hot instruction class (all zero if unsupported)
//   illegal_o         high when the opcode/funct is not supported
module mc_decode
  import mc_pkg::*;
(
  input  logic [31:0] instr_i,
  output iclass_t     cls_o,
  output logic        illegal_o
);

  logic [5:0] opcode_s;
  logic [5:0] funct_s;
  // Register/immediate fields are irrelevant to classification.
  logic       unused_fields_s;

  assign opcode_s        = instr_i[31:26];
  assign funct_s         = instr_i[5:0];
  assign unused_fields_s = ^instr_i[25:6];

  // Map opcode (and funct for R-type) to a single class bit.
  always_comb begin
    cls_o = '0;
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADDU: cls_o.addu = 1'b1;
          FN_SUBU: cls_o.subu = 1'b1;
          FN_JR:   cls_o.jr   = 1'b1;
          default: cls_o      = '0;
        endcase
      end
      OP_ORI:  cls_o.ori = 1'b1;
      OP_LUI:  cls_o.lui = 1'b1;
      OP_LW:   cls_o.lw  = 1'b1;
      OP_SW:   cls_o.sw  = 1'b1;
      OP_BEQ:  cls_o.beq = 1'b1;
      OP_J:    cls_o.j   = 1'b1;
      OP_JAL:  cls_o.jal = 1'b1;
      default: cls_o     = '0;
    endcase
  end

  assign illegal_o = ~(|cls_o);

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control unit (FETCH/DECODE/EXE/MEM/WB) for the
// MIPS datapath. Memory states last MEM_LAT+1 cycles.
// Ports:
//   clk, reset (async, active-low)
//   instr [31:0]  IR contents, valid from DECODE onward
//   zero          ALU equality flag, used only for beq in EXE
//   pc_we, ir_we, npc_sel, regwrite, regdst, wdsel, alusrc, extop,
//   aluctrl, memwrite  datapath enables and selects
//   state [2:0]   current FSM state (debug)
//   retired       retired-instruction count, wraps
//   illegal       sticky unsupported-instruction flag
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  output logic             pc_we,
  output logic             ir_we,
  output logic [1:0]       npc_sel,
  output logic             regwrite,
  output logic [1:0]       regdst,
  output logic [1:0]       wdsel,
  output logic             alusrc,
  output logic [1:0]       extop,
  output logic [1:0]       aluctrl,
  output logic             memwrite,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  localparam logic [2:0] LAT_C = 3'(MEM_LAT);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  iclass_t          cls_q, cls_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  iclass_t          dec_cls_s;
  logic             dec_ill_s;
  iclass_t          cls_s;
  logic             last_s;

  logic             pc_we_s, ir_we_s, regwrite_s, alusrc_s, memwrite_s;
  logic [1:0]       npc_sel_s, regdst_s, wdsel_s, extop_s, aluctrl_s;

  mc_decode u_decode (
    .instr_i   (instr),
    .cls_o     (dec_cls_s),
    .illegal_o (dec_ill_s)
  );

  // In DECODE the class register is not loaded yet, so use the decoder directly.
  assign cls_s  = (state_q == ST_DECODE) ? dec_cls_s : cls_q;
  assign last_s = (cnt_q == LAT_C);

  // Next-state, wait counter, class latch and counter update.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (last_s) state_d = ST_DECODE;
        else        state_d = ST_FETCH;
      end
      ST_DECODE: begin
        if (dec_cls_s.j || dec_ill_s) state_d = ST_FETCH;
        else if (dec_cls_s.jal)       state_d = ST_WB;
        else                          state_d = ST_EXE;
      end
      ST_EXE: begin
        if (cls_s.beq || cls_s.jr)    state_d = ST_FETCH;
        else if (cls_s.lw || cls_s.sw) state_d = ST_MEM;
        else                          state_d = ST_WB;
      end
      ST_MEM: begin
        if (!last_s)      state_d = ST_MEM;
        else if (cls_s.sw) state_d = ST_FETCH;
        else              state_d = ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase

    // Only FETCH and MEM dwell, so clearing on any transition clears on entry.
    if (state_d != state_q) cnt_d = 3'd0;
    else                    cnt_d = cnt_q + 3'd1;

    if (state_q == ST_DECODE) cls_d = dec_cls_s;
    else                      cls_d = cls_q;

    if ((state_d == ST_FETCH) && (state_q != ST_FETCH))
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    else
      retired_d = retired_q;

    if ((state_q == ST_DECODE) && dec_ill_s) illegal_d = 1'b1;
    else                                     illegal_d = illegal_q;
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      cnt_q     <= 3'd0;
      cls_q     <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cls_q     <= cls_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Datapath controls from state, wait counter and decoded class.
  always_comb begin
    pc_we_s    = 1'b0;
    ir_we_s    = 1'b0;
    npc_sel_s  = NPC_PC4;
    regwrite_s = 1'b0;
    regdst_s   = RD_RT;
    wdsel_s    = WD_ALU;
    memwrite_s = 1'b0;
    alusrc_s   = 1'b0;
    extop_s    = EXT_ZERO;
    aluctrl_s  = ALU_ADD;

    // Operand selects stay stable from DECODE through WB.
    if (state_q != ST_FETCH) begin
      alusrc_s = cls_s.ori | cls_s.lui | cls_s.lw | cls_s.sw;
      if (cls_s.lui)              extop_s = EXT_LUI;
      else if (cls_s.lw | cls_s.sw) extop_s = EXT_SIGN;
      else                        extop_s = EXT_ZERO;
      if (cls_s.subu | cls_s.beq) aluctrl_s = ALU_SUB;
      else if (cls_s.ori)         aluctrl_s = ALU_OR;
      else                        aluctrl_s = ALU_ADD;
    end else begin
      alusrc_s  = 1'b0;
      extop_s   = EXT_ZERO;
      aluctrl_s = ALU_ADD;
    end

    case (state_q)
      ST_FETCH: begin
        ir_we_s = last_s;
        pc_we_s = last_s;
      end
      ST_DECODE: begin
        if (cls_s.j) begin
          pc_we_s   = 1'b1;
          npc_sel_s = NPC_JMP;
        end else begin
          pc_we_s   = 1'b0;
        end
      end
      ST_EXE: begin
        if (cls_s.beq) begin
          pc_we_s   = zero;
          npc_sel_s = NPC_BR;
        end else if (cls_s.jr) begin
          pc_we_s   = 1'b1;
          npc_sel_s = NPC_RS;
        end else begin
          pc_we_s   = 1'b0;
        end
      end
      ST_MEM: memwrite_s = cls_s.sw & last_s;
      ST_WB: begin
        regwrite_s = 1'b1;
        if (cls_s.addu | cls_s.subu) begin
          regdst_s = RD_RD;
          wdsel_s  = WD_ALU;
        end else if (cls_s.lw) begin
          regdst_s = RD_RT;
          wdsel_s  = WD_MEM;
        end else if (cls_s.jal) begin
          regdst_s  = RD_RA;
          wdsel_s   = WD_PC;
          pc_we_s   = 1'b1;
          npc_sel_s = NPC_JMP;
        end else begin
          regdst_s = RD_RT;
          wdsel_s  = WD_ALU;
        end
      end
      default: pc_we_s = 1'b0;
    endcase
  end

  // Reset gating keeps FETCH with MEM_LAT=0 from raising ir_we/pc_we in reset.
  assign pc_we    = reset & pc_we_s;
  assign ir_we    = reset & ir_we_s;
  assign regwrite = reset & regwrite_s;
  assign memwrite = reset & memwrite_s;
  assign alusrc   = reset & alusrc_s;
  assign npc_sel  = reset ? npc_sel_s : 2'd0;
  assign regdst   = reset ? regdst_s  : 2'd0;
  assign wdsel    = reset ? wdsel_s   : 2'd0;
  assign extop    = reset ? extop_s   : 2'd0;
  assign aluctrl  = reset ? aluctrl_s : 2'd0;
  assign state    = state_q;
  assign retired  = retired_q;
  assign illegal  = illegal_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. Three instances with
// MEM_LAT = 1, 3, 0 are exercised one at a time; each instruction's
// expected per-cycle control word is built from the instruction-level
// sequencing rules and compared on the falling clock edge.
module tb_mc_ctrl;

  localparam int NDUT = 3;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9, K_ILL = 10;

  function automatic int lat_of(input int k);
    if (k == 0)      return 1;
    else if (k == 1) return 3;
    else             return 0;
  endfunction

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_v [NDUT];
  logic [31:0] instr_v [NDUT];
  logic        zero_v  [NDUT];
  logic [17:0] obs_v   [NDUT];
  logic [31:0] ret_v   [NDUT];
  logic        ill_v   [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LAT = lat_of(g);
    logic        pc_we, ir_we, regwrite, alusrc, memwrite, illegal;
    logic [1:0]  npc_sel, regdst, wdsel, extop, aluctrl;
    logic [2:0]  state;
    logic [31:0] retired;

    mc_ctrl #(.MEM_LAT(LAT), .CNT_W(32)) u_dut (
      .clk(clk), .reset(reset_v[g]), .instr(instr_v[g]), .zero(zero_v[g]),
      .pc_we(pc_we), .ir_we(ir_we), .npc_sel(npc_sel), .regwrite(regwrite),
      .regdst(regdst), .wdsel(wdsel), .alusrc(alusrc), .extop(extop),
      .aluctrl(aluctrl), .memwrite(memwrite), .state(state),
      .retired(retired), .illegal(illegal)
    );

    // Control word: pc_we ir_we npc_sel regwrite regdst wdsel alusrc extop aluctrl memwrite state
    assign obs_v[g] = {pc_we, ir_we, npc_sel, regwrite, regdst, wdsel,
                       alusrc, extop, aluctrl, memwrite, state};
    assign ret_v[g] = retired;
    assign ill_v[g] = illegal;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [17:0] exp_q [$];
  logic [17:0] msk_q [$];
  logic [4:0]  sel_c, selm_c;
  logic [31:0] m_ret [NDUT];
  logic        m_ill [NDUT];

  function automatic int kind_of(input logic [31:0] ins);
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h21:   return K_ADDU;
          6'h23:   return K_SUBU;
          6'h08:   return K_JR;
          default: return K_ILL;
        endcase
      end
      6'h0D:   return K_ORI;
      6'h0F:   return K_LUI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [31:0] make_instr(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      K_ADDU: return {6'h00, r[25:6], 6'h21};
      K_SUBU: return {6'h00, r[25:6], 6'h23};
      K_JR:   return {6'h00, r[25:6], 6'h08};
      K_ORI:  return {6'h0D, r[25:0]};
      K_LUI:  return {6'h0F, r[25:0]};
      K_LW:   return {6'h23, r[25:0]};
      K_SW:   return {6'h2B, r[25:0]};
      K_BEQ:  return {6'h04, r[25:0]};
      K_J:    return {6'h02, r[25:0]};
      K_JAL:  return {6'h03, r[25:0]};
      default: begin
        case ($urandom_range(0, 2))
          0:       return {6'h3F, r[25:0]};
          1:       return {6'h00, r[25:6], 6'h20};
          default: return {6'h08, r[25:0]};
        endcase
      end
    endcase
  endfunction

  function automatic logic [17:0] w(input logic [2:0] st, input logic pcwe, input logic irwe,
                                    input logic [1:0] npc, input logic rw, input logic [1:0] rd,
                                    input logic [1:0] wd, input logic mw);
    return {pcwe, irwe, npc, rw, rd, wd, 5'd0, mw, st};
  endfunction

  function automatic void push_cyc(input logic [17:0] word, input bit fetch);
    exp_q.push_back(fetch ? word : (word | {9'd0, sel_c, 4'd0}));
    msk_q.push_back(fetch ? 18'h3FE0F : {9'h1FF, selm_c, 4'hF});
  endfunction

  // Expected cycle-by-cycle control words for one instruction.
  function automatic void build(input int lat, input int kind, input logic z);
    exp_q.delete();
    msk_q.delete();
    case (kind)
      K_ADDU:      begin sel_c = 5'b0_00_00; selm_c = 5'b11111; end
      K_SUBU:      begin sel_c = 5'b0_00_01; selm_c = 5'b11111; end
      K_ORI:       begin sel_c = 5'b1_00_10; selm_c = 5'b11111; end
      K_LUI:       begin sel_c = 5'b1_10_00; selm_c = 5'b11100; end
      K_LW, K_SW:  begin sel_c = 5'b1_01_00; selm_c = 5'b11111; end
      K_BEQ:       begin sel_c = 5'b0_00_01; selm_c = 5'b10011; end
      default:     begin sel_c = 5'b0_00_00; selm_c = 5'b00000; end
    endcase
    for (int i = 0; i <= lat; i++)
      push_cyc(w(3'd0, i == lat, i == lat, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0), 1'b1);
    if (kind == K_J) begin
      push_cyc(w(3'd1, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0), 1'b0);
      return;
    end
    push_cyc(w(3'd1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0), 1'b0);
    if (kind == K_ILL) return;
    if (kind != K_JAL) begin
      if (kind == K_BEQ) begin
        push_cyc(w(3'd2, z, 1'b0, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0), 1'b0);
        return;
      end
      if (kind == K_JR) begin
        push_cyc(w(3'd2, 1'b1, 1'b0, 2'd3, 1'b0, 2'd0, 2'd0, 1'b0), 1'b0);
        return;
      end
      push_cyc(w(3'd2, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0), 1'b0);
      if (kind == K_LW || kind == K_SW) begin
        for (int i = 0; i <= lat; i++)
          push_cyc(w(3'd3, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0,
                     (kind == K_SW) && (i == lat)), 1'b0);
        if (kind == K_SW) return;
      end
    end
    case (kind)
      K_ADDU, K_SUBU: push_cyc(w(3'd4, 1'b0, 1'b0, 2'd0, 1'b1, 2'd1, 2'd0, 1'b0), 1'b0);
      K_LW:           push_cyc(w(3'd4, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd1, 1'b0), 1'b0);
      K_JAL:          push_cyc(w(3'd4, 1'b1, 1'b0, 2'd2, 1'b1, 2'd2, 2'd2, 1'b0), 1'b0);
      default:        push_cyc(w(3'd4, 1'b0, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 1'b0), 1'b0);
    endcase
  endfunction

  // Called just after the edge that entered FETCH; returns just after the
  // edge that re-enters FETCH.
  task automatic run_instr(input int k, input logic [31:0] ins, input logic z);
    int kind;
    kind = kind_of(ins);
    instr_v[k] = ins;
    zero_v[k]  = z;
    build(lat_of(k), kind, z);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check_eq($sformatf("d%0d_k%0d_cyc%0d", k, kind, i), {14'd0, obs_v[k] & msk_q[i]},
               {14'd0, exp_q[i] & msk_q[i]});
    end
    @(posedge clk);
    #1;
    m_ret[k] = m_ret[k] + 32'd1;
    if (kind == K_ILL) m_ill[k] = 1'b1;
    check_eq($sformatf("d%0d_retired", k), ret_v[k], m_ret[k]);
    check_eq($sformatf("d%0d_illegal", k), {31'd0, ill_v[k]}, {31'd0, m_ill[k]});
    check_eq($sformatf("d%0d_refetch", k), {29'd0, obs_v[k][2:0]}, 32'd0);
  endtask

  task automatic run_random(input int k, input int n);
    for (int i = 0; i < n; i++)
      run_instr(k, make_instr($urandom_range(0, 10)), 1'($urandom_range(0, 1)));
  endtask

  task automatic release_dut(input int k);
    @(posedge clk);
    #1;
    reset_v[k] = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      reset_v[k] = 1'b0;
      instr_v[k] = 32'd0;
      zero_v[k]  = 1'b0;
      m_ret[k]   = 32'd0;
      m_ill[k]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      check_eq($sformatf("d%0d_rst_outputs", k), {14'd0, obs_v[k]}, 32'd0);
      check_eq($sformatf("d%0d_rst_retired", k), ret_v[k], 32'd0);
      check_eq($sformatf("d%0d_rst_illegal", k), {31'd0, ill_v[k]}, 32'd0);
    end

    // MEM_LAT = 1
    release_dut(0);
    run_instr(0, make_instr(K_ADDU), 1'b0);
    run_instr(0, make_instr(K_BEQ), 1'b1);
    run_instr(0, make_instr(K_BEQ), 1'b0);
    run_instr(0, make_instr(K_JAL), 1'b0);
    run_instr(0, {6'h3F, 26'h0123456}, 1'b0);
    run_instr(0, make_instr(K_ADDU), 1'b0);
    run_instr(0, make_instr(K_JR), 1'b0);
    run_random(0, 40);
    reset_v[0] = 1'b0;

    // MEM_LAT = 3
    release_dut(1);
    run_instr(1, make_instr(K_LW), 1'b0);
    run_instr(1, make_instr(K_SW), 1'b0);
    run_random(1, 30);
    // Reset in the middle of a sw memory phase (MEM, second cycle).
    instr_v[1] = make_instr(K_SW);
    repeat (8) @(negedge clk);
    check_eq("midmem_state", {29'd0, obs_v[1][2:0]}, 32'd3);
    #1;
    reset_v[1] = 1'b0;
    #1;
    check_eq("midmem_rst_outputs", {14'd0, obs_v[1]}, 32'd0);
    check_eq("midmem_rst_retired", ret_v[1], 32'd0);
    check_eq("midmem_rst_illegal", {31'd0, ill_v[1]}, 32'd0);
    m_ret[1] = 32'd0;
    m_ill[1] = 1'b0;
    release_dut(1);
    run_instr(1, make_instr(K_ADDU), 1'b0);
    reset_v[1] = 1'b0;

    // MEM_LAT = 0
    release_dut(2);
    run_instr(2, make_instr(K_SW), 1'b0);
    run_instr(2, make_instr(K_J), 1'b0);
    run_instr(2, make_instr(K_LW), 1'b0);
    run_random(2, 30);
    reset_v[2] = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
